// File: rtl/sel_rr_arbiter.sv
// sel_rr_arbiter: 4-requester round-robin arbiter that drives the select code
// of a 4:1 selector. A grant lasts while its request stays high and enable
// is set. It is forcibly ended after MAX_HOLD cycles. Every release is
// followed by at least one idle cycle before the next grant.
module sel_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       preempt
);

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  logic       state;
  logic [1:0] ptr;
  logic [3:0] hold_cnt;
  logic [1:0] winner;
  logic       found;
  logic [1:0] idx;

  // Rotating priority search: first set request starting at ptr, wrapping 3 -> 0
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Grant/idle state machine with registered outputs; sel holds through idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      valid    <= 1'b0;
      preempt  <= 1'b0;
    end else if (state == IDLE) begin
      preempt <= 1'b0;
      if (en && found) begin
        state    <= GRANT;
        gnt      <= 4'b0001 << winner;
        sel      <= winner;
        valid    <= 1'b1;
        hold_cnt <= 4'd1;
      end
    end else begin
      if (!req[sel] || !en) begin
        state    <= IDLE;
        gnt      <= '0;
        valid    <= 1'b0;
        ptr      <= sel + 2'd1;
        hold_cnt <= '0;
        preempt  <= 1'b0;
      end else if (hold_cnt >= HOLD_LIMIT) begin
        state    <= IDLE;
        gnt      <= '0;
        valid    <= 1'b0;
        ptr      <= sel + 2'd1;
        hold_cnt <= '0;
        preempt  <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 4'd1;
      end
    end
  end

endmodule

// File: doc/sel_rr_arbiter.md
SEL_RR_ARBITER -- requirements
Module: sel_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per requester; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 EN  input  1  arbitration enable; 0 blocks new grants and releases any active grant.
REQ-005 REQ  input  4  request vector; bit i = requester i wants the 4:1 selector; level-held.
REQ-006 GNT  output  4  one-hot grant vector, registered; all-zero when no grant.
REQ-007 SEL  output  2  registered select code driving the 4:1 selector; equals the index of the granted requester.
REQ-008 VALID  output  1  registered; 1 when exactly one GNT bit is set.
REQ-009 PREEMPT  output  1  registered one-cycle pulse when a grant is forcibly ended by hold timeout.

Function
REQ-010 The block SHALL implement two states: IDLE and GRANT; internal 2-bit round-robin pointer PTR and 4-bit HOLD_CNT.
REQ-011 In IDLE, GNT=0000, VALID=0; SEL SHALL retain its last value so the selector output stays stable.
REQ-012 IDLE, edge with EN=1 and REQ!=0: SHALL enter GRANT; winner = first set REQ bit searching PTR, PTR+1, ... modulo 4 (3 wraps to 0); GNT=one-hot(winner), SEL=winner, VALID=1, HOLD_CNT=1.
REQ-013 IDLE, edge with EN=0 or REQ=0: SHALL remain IDLE, no output change.
REQ-014 GRANT, edge with REQ[SEL]=0 or EN=0: SHALL enter IDLE, PTR=SEL+1 mod 4, PREEMPT=0.
REQ-015 GRANT, edge with REQ[SEL]=1, EN=1, HOLD_CNT=MAX_HOLD: SHALL enter IDLE, PTR=SEL+1 mod 4, PREEMPT=1 for exactly that following cycle.
REQ-016 GRANT, otherwise: SHALL stay in GRANT, HOLD_CNT increments, GNT/SEL unchanged.
REQ-017 Grant latency SHALL be one edge from REQ sampled high in IDLE; release latency one edge; every release is followed by at least one IDLE cycle (no back-to-back grant without gap).
REQ-018 A single requester held continuously SHALL be preempted every MAX_HOLD cycles and re-granted after the IDLE gap if no other requester is pending.
REQ-019 Changes to non-granted REQ bits during GRANT SHALL have no effect until the next IDLE evaluation.
REQ-020 GNT SHALL never have more than one bit set; VALID SHALL equal (GNT!=0).

Reset
REQ-021 RST_N=0 SHALL immediately, without clock, force state=IDLE, PTR=0, HOLD_CNT=0, GNT=0000, SEL=00, VALID=0, PREEMPT=0, including mid-grant.
REQ-022 After RST_N rises, the first evaluating edge SHALL follow REQ-012 with PTR=0.

Verification
REQ-023 Reset, REQ=0010, EN=1 -> edge 1: GNT=0010, SEL=01, VALID=1; drop REQ -> next edge GNT=0000, VALID=0, SEL stays 01, PTR=2.
REQ-024 REQ=1111 held, MAX_HOLD=8 -> grants 0,1,2,3,0 in order, each GNT asserted 8 cycles, 1 IDLE cycle between, PREEMPT pulses once per handover.
REQ-025 PTR=3 (after serving 2), REQ=1001 -> grant to 3 first, then after release grant to 0 (wrap-around).
REQ-026 Grant to 1 active, EN driven 0 -> next edge GNT=0000, PREEMPT=0; no grant while EN=0 despite REQ=1111; EN=1 -> grant to 2.
REQ-027 Grant to 2 active at HOLD_CNT=5, RST_N pulsed low mid-cycle -> outputs zero immediately; RST_N high with REQ=0100 -> next edge GNT=0100, HOLD_CNT restarts at 1.
REQ-028 MAX_HOLD=1, REQ=0001 held -> GNT alternates 0001/0000 each cycle, PREEMPT=1 in every IDLE cycle.
